// File: rtl/counter_step_driver.sv
// counter_step_driver: initiator side of the step-counter interface.
// Takes a job from the sequencer, loads the counter, pulses step_en until
// the counter reports finish, recounts for each further round, then reports done.
module counter_step_driver #(
  parameter int COUNTER_BITWIDTH = 8,
  parameter int REPEAT_BITWIDTH  = 8,
  parameter int GAP_BITWIDTH     = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        en_i,
  input  logic                        abort_i,
  input  logic                        start_valid_i,
  output logic                        start_ready_o,
  input  logic [COUNTER_BITWIDTH-1:0] start_count_i,
  input  logic [REPEAT_BITWIDTH-1:0]  start_repeat_i,
  input  logic [GAP_BITWIDTH-1:0]     start_gap_i,
  output logic                        config_valid_o,
  output logic [COUNTER_BITWIDTH-1:0] config_counter_o,
  input  logic                        config_ready_i,
  output logic                        recount_en_o,
  output logic                        step_en_o,
  input  logic                        counter_ready_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic [REPEAT_BITWIDTH-1:0]  rounds_o
);

  localparam int CW = COUNTER_BITWIDTH;
  localparam int RW = REPEAT_BITWIDTH;
  localparam int GW = GAP_BITWIDTH;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SETTLE,
    S_STEP,
    S_GAP,
    S_RECOUNT,
    S_DONE
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_count;
  logic [RW-1:0] r_repeat;
  logic [GW-1:0] r_gap;
  logic [GW-1:0] r_gap_cnt;
  logic [RW-1:0] r_rounds;
  logic          r_abort_pend;

  logic [RW:0]   w_round_inc;
  logic          w_round_last;
  logic [RW-1:0] w_rounds_sat;
  logic          w_finish;

  assign w_round_inc  = {1'b0, r_rounds} + (RW+1)'(1);
  assign w_round_last = (w_round_inc == {1'b0, r_repeat});
  assign w_rounds_sat = (&r_rounds) ? r_rounds : w_round_inc[RW-1:0];
  assign w_finish     = (r_state == S_STEP) && en_i && !abort_i && counter_ready_i;
  assign rounds_o     = r_rounds;

  // Next-state and output decode
  always_comb begin
    w_state_nxt      = r_state;
    start_ready_o    = 1'b0;
    config_valid_o   = 1'b0;
    config_counter_o = '0;
    recount_en_o     = 1'b0;
    step_en_o        = 1'b0;
    done_o           = 1'b0;
    busy_o           = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        start_ready_o = 1'b1;
        if (start_valid_i) w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        config_valid_o   = 1'b1;
        config_counter_o = r_count;
        if (config_ready_i) w_state_nxt = S_SETTLE;
      end
      S_SETTLE: begin
        // An abort seen while loading is acted on here, once the load has landed.
        if (abort_i || r_abort_pend) w_state_nxt = S_IDLE;
        else                         w_state_nxt = S_STEP;
      end
      S_STEP: begin
        if (abort_i) begin
          w_state_nxt = S_IDLE;
        end else if (en_i) begin
          if (counter_ready_i) begin
            w_state_nxt = w_round_last ? S_DONE : S_RECOUNT;
          end else begin
            step_en_o   = 1'b1;
            w_state_nxt = (r_gap != '0) ? S_GAP : S_STEP;
          end
        end
      end
      S_GAP: begin
        if (abort_i)                           w_state_nxt = S_IDLE;
        else if (en_i && (r_gap_cnt <= GW'(1))) w_state_nxt = S_STEP;
      end
      S_RECOUNT: begin
        if (abort_i) begin
          w_state_nxt = S_IDLE;
        end else if (en_i) begin
          recount_en_o = 1'b1;
          w_state_nxt  = S_SETTLE;
        end
      end
      S_DONE: begin
        done_o      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, job latches, gap countdown and round counter
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= S_IDLE;
      r_count      <= '0;
      r_repeat     <= '0;
      r_gap        <= '0;
      r_gap_cnt    <= '0;
      r_rounds     <= '0;
      r_abort_pend <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == S_IDLE) && start_valid_i) begin
        r_count  <= start_count_i;
        r_repeat <= (start_repeat_i == '0) ? RW'(1) : start_repeat_i;
        r_gap    <= start_gap_i;
        r_rounds <= '0;
      end
      r_abort_pend <= (r_state == S_LOAD) ? (r_abort_pend | abort_i) : 1'b0;
      if ((r_state == S_STEP) && (w_state_nxt == S_GAP))
        r_gap_cnt <= r_gap;
      else if ((r_state == S_GAP) && en_i && !abort_i)
        r_gap_cnt <= r_gap_cnt - GW'(1);
      if (w_finish)
        r_rounds <= w_rounds_sat;
    end
  end

endmodule

// File: tb/tb_counter_step_driver.sv
// Directed bench for counter_step_driver with a behavioural step counter.
module tb_counter_step_driver;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       en_i = 1'b1;
  logic       abort_i = 1'b0;
  logic       start_valid_i = 1'b0;
  logic       start_ready_o;
  logic [7:0] start_count_i = '0;
  logic [7:0] start_repeat_i = '0;
  logic [3:0] start_gap_i = '0;
  logic       config_valid_o;
  logic [7:0] config_counter_o;
  logic       config_ready_i = 1'b1;
  logic       recount_en_o;
  logic       step_en_o;
  logic       counter_ready_i;
  logic       busy_o;
  logic       done_o;
  logic [7:0] rounds_o;

  counter_step_driver #(
    .COUNTER_BITWIDTH(8),
    .REPEAT_BITWIDTH (8),
    .GAP_BITWIDTH    (4)
  ) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .en_i            (en_i),
    .abort_i         (abort_i),
    .start_valid_i   (start_valid_i),
    .start_ready_o   (start_ready_o),
    .start_count_i   (start_count_i),
    .start_repeat_i  (start_repeat_i),
    .start_gap_i     (start_gap_i),
    .config_valid_o  (config_valid_o),
    .config_counter_o(config_counter_o),
    .config_ready_i  (config_ready_i),
    .recount_en_o    (recount_en_o),
    .step_en_o       (step_en_o),
    .counter_ready_i (counter_ready_i),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .rounds_o        (rounds_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  int t0  = 0;
  int n_checks = 0;
  int n_errors = 0;
  int step_q[$];
  int rec_q[$];
  int done_q[$];

  always @(posedge clk_i) cyc <= cyc + 1;

  // Counter model: load on config handshake, reload on recount, count down on step
  logic [7:0] q_cnt, q_stored;
  always @(posedge clk_i) begin
    if (rst_i) begin
      q_cnt    <= '0;
      q_stored <= '0;
    end else if (config_valid_o && config_ready_i) begin
      q_cnt    <= config_counter_o;
      q_stored <= config_counter_o;
    end else if (recount_en_o) begin
      q_cnt <= q_stored;
    end else if (step_en_o && q_cnt != 0) begin
      q_cnt <= q_cnt - 8'd1;
    end
  end
  assign counter_ready_i = (q_cnt == 8'd0);

  // Record pulse times relative to the job handshake cycle
  always @(negedge clk_i) begin
    if (step_en_o)    step_q.push_back(cyc - t0);
    if (recount_en_o) rec_q.push_back(cyc - t0);
    if (done_o)       done_q.push_back(cyc - t0);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int step_at(input int k);
    return (step_q.size() > k) ? step_q[k] : -1;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic goto_cyc(input int c);
    while (cyc < c) tick();
  endtask

  task automatic start_job(input int cnt, input int rep, input int gap);
    tick();
    start_valid_i  = 1'b1;
    start_count_i  = 8'(cnt);
    start_repeat_i = 8'(rep);
    start_gap_i    = 4'(gap);
    t0 = cyc;
    step_q.delete();
    rec_q.delete();
    done_q.delete();
    tick();
    start_valid_i = 1'b0;
    chk("busy_after_accept", 32'(busy_o), 32'd1);
    chk("cfg_valid_c1", 32'(config_valid_o), 32'd1);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 300; i++) begin
      if (done_q.size() != 0) break;
      tick();
    end
    chk("done_seen", 32'(done_q.size() != 0), 32'd1);
    repeat (3) tick();
    chk("done_once", 32'(done_q.size()), 32'd1);
    chk("idle_after_done", 32'(busy_o), 32'd0);
  endtask

  initial begin
    repeat (3) tick();
    rst_i = 1'b0;
    chk("rst_start_ready", 32'(start_ready_o), 32'd1);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_cfg_valid", 32'(config_valid_o), 32'd0);
    chk("rst_cfg_counter", 32'(config_counter_o), 32'd0);
    chk("rst_pulses", 32'({step_en_o, recount_en_o, done_o}), 32'd0);
    chk("rst_rounds", 32'(rounds_o), 32'd0);

    // 1: count=3 repeat=1 gap=0
    start_job(3, 1, 0);
    chk("t1_cfg_counter", 32'(config_counter_o), 32'd3);
    wait_done();
    chk("t1_nsteps", 32'(step_q.size()), 32'd3);
    chk("t1_step0", 32'(step_at(0)), 32'd3);
    chk("t1_step1", 32'(step_at(1)), 32'd4);
    chk("t1_step2", 32'(step_at(2)), 32'd5);
    chk("t1_done_cyc", 32'(done_q[0]), 32'd7);
    chk("t1_rounds", 32'(rounds_o), 32'd1);

    // 2: count=4 gap=2 -> pulses 3 cycles apart
    start_job(4, 1, 2);
    wait_done();
    chk("t2_nsteps", 32'(step_q.size()), 32'd4);
    chk("t2_step0", 32'(step_at(0)), 32'd3);
    for (int i = 1; i < 4; i++)
      chk("t2_spacing", 32'(step_at(i) - step_at(i-1)), 32'd3);
    chk("t2_done_cyc", 32'(done_q[0]), 32'd16);

    // 3: count=0 repeat=2
    start_job(0, 2, 0);
    wait_done();
    chk("t3_nsteps", 32'(step_q.size()), 32'd0);
    chk("t3_nrec", 32'(rec_q.size()), 32'd1);
    chk("t3_done_cyc", 32'(done_q[0]), 32'd7);
    chk("t3_rounds", 32'(rounds_o), 32'd2);

    // 4: count=3 repeat=3
    start_job(3, 3, 0);
    wait_done();
    chk("t4_nsteps", 32'(step_q.size()), 32'd9);
    chk("t4_nrec", 32'(rec_q.size()), 32'd2);
    chk("t4_rec0", 32'((rec_q.size() > 0) ? rec_q[0] : -1), 32'd7);
    chk("t4_rec1", 32'((rec_q.size() > 1) ? rec_q[1] : -1), 32'd13);
    chk("t4_settle0", 32'(step_at(3)), 32'd9);
    chk("t4_settle1", 32'(step_at(6)), 32'd15);
    chk("t4_done_cyc", 32'(done_q[0]), 32'd19);
    chk("t4_rounds", 32'(rounds_o), 32'd3);

    // repeat=0 is one round
    start_job(2, 0, 0);
    wait_done();
    chk("rep0_nsteps", 32'(step_q.size()), 32'd2);
    chk("rep0_rounds", 32'(rounds_o), 32'd1);

    // 5: config_ready low in LOAD for 5 cycles, abort pulse during LOAD
    config_ready_i = 1'b0;
    start_job(7, 1, 0);
    for (int i = 0; i < 5; i++) begin
      chk("t5_cfg_valid_hold", 32'(config_valid_o), 32'd1);
      chk("t5_cfg_data_hold", 32'(config_counter_o), 32'd7);
      abort_i = (i == 1);
      tick();
    end
    abort_i = 1'b0;
    config_ready_i = 1'b1;
    repeat (8) tick();
    chk("t5_nsteps", 32'(step_q.size()), 32'd0);
    chk("t5_ndone", 32'(done_q.size()), 32'd0);
    chk("t5_idle", 32'(busy_o), 32'd0);
    chk("t5_start_ready", 32'(start_ready_o), 32'd1);

    // 6a: en_i low for 4 cycles after 2nd step, count=5
    start_job(5, 1, 0);
    goto_cyc(t0 + 5);
    en_i = 1'b0;
    goto_cyc(t0 + 9);
    chk("t6_busy_while_paused", 32'(busy_o), 32'd1);
    en_i = 1'b1;
    wait_done();
    chk("t6_nsteps", 32'(step_q.size()), 32'd5);
    chk("t6_step1", 32'(step_at(1)), 32'd4);
    chk("t6_step2", 32'(step_at(2)), 32'd9);
    chk("t6_step4", 32'(step_at(4)), 32'd11);
    chk("t6_done_cyc", 32'(done_q[0]), 32'd13);

    // 6b: reset during GAP
    start_job(5, 1, 3);
    goto_cyc(t0 + 5);
    chk("t6r_busy_in_gap", 32'(busy_o), 32'd1);
    rst_i = 1'b1;
    tick();
    chk("t6r_busy", 32'(busy_o), 32'd0);
    chk("t6r_start_ready", 32'(start_ready_o), 32'd1);
    chk("t6r_outs", 32'({config_valid_o, step_en_o, recount_en_o, done_o}), 32'd0);
    chk("t6r_rounds", 32'(rounds_o), 32'd0);
    rst_i = 1'b0;
    repeat (6) tick();
    chk("t6r_nsteps", 32'(step_q.size()), 32'd1);
    chk("t6r_ndone", 32'(done_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
